// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use and branch stalls,
// exception flushes, and the two-state handshake with the iterative divider.
module hazard_unit #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteE,
  input  logic              regwriteM,
  input  logic              regwriteW,
  input  logic              memtoregE,
  input  logic              memtoregM,
  input  logic              branchD,
  input  logic              jrD,
  input  logic              divE,
  input  logic              div_ready,
  input  logic              exceptM,
  output logic              div_start,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              stallW,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic              forwardaD,
  output logic              forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE
);

  // state | meaning
  // IDLE  | no divide in flight; a DIV arriving in E starts one
  // BUSY  | divider running; E is held until div_ready or an exception
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} div_state_e;

  div_state_e state_q;

  logic lwstall;
  logic branchstall;
  logic divstall;
  logic br_hit_e;
  logic br_hit_m;

  // Divider state: exceptions abort a running divide, reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (divE && !exceptM) state_q <= BUSY;
        BUSY:    if (div_ready || exceptM) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // E-stage operand forwarding; the M stage is newer so it wins over W.
  always_comb begin
    forwardaE = 2'b00;
    if (rsE != '0 && regwriteM && rsE == writeregM)      forwardaE = 2'b10;
    else if (rsE != '0 && regwriteW && rsE == writeregW) forwardaE = 2'b01;
    forwardbE = 2'b00;
    if (rtE != '0 && regwriteM && rtE == writeregM)      forwardbE = 2'b10;
    else if (rtE != '0 && regwriteW && rtE == writeregW) forwardbE = 2'b01;
  end

  // D-stage comparator forwarding from M only.
  always_comb begin
    forwardaD = (rsD != '0) && regwriteM && (rsD == writeregM);
    forwardbD = (rtD != '0) && regwriteM && (rtD == writeregM);
  end

  // Stall sources. Register 0 may match here: an extra stall is harmless.
  always_comb begin
    lwstall     = memtoregE && ((rtE == rsD) || (rtE == rtD));
    br_hit_e    = regwriteE && ((writeregE == rsD) || (writeregE == rtD));
    br_hit_m    = memtoregM && ((writeregM == rsD) || (writeregM == rtD));
    branchstall = (branchD || jrD) && (br_hit_e || br_hit_m);
    // Released in the div_ready cycle so the DIV leaves E at the next edge.
    div_start   = ((state_q == IDLE) && divE && !exceptM) ||
                  ((state_q == BUSY) && !div_ready && !exceptM);
    divstall    = div_start;
  end

  // Stall/flush combination; an exception flushes everything and stalls nothing.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    stallW = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    flushW = 1'b0;
    if (exceptM) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else begin
      stallF = lwstall || branchstall || divstall;
      stallD = lwstall || branchstall || divstall;
      stallE = divstall;
      flushE = (lwstall || branchstall) && !divstall;
      // Bubble into M while the DIV is held in E.
      flushM = divstall;
    end
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The module SHALL have parameter REG_AW, default 5, giving the register-address width; all ports below marked "ra" are REG_AW bits wide.
REQ-002 The module SHALL have these ports:
  clk  in  1  the single clock; all state SHALL be updated on its rising edge.
  rst  in  1  synchronous, active-high reset.
  rsD, rtD  in  ra  source registers of the instruction in D.
  rsE, rtE  in  ra  source registers of the instruction in E.
  writeregE, writeregM, writeregW  in  ra  destination registers of the instructions in E, M and W.
  regwriteE, regwriteM, regwriteW  in  1  register-write enables of the instructions in E, M and W.
  memtoregE, memtoregM  in  1  the instruction in E or M is a load.
  branchD, jrD  in  1  the instruction in D is a branch or a register jump.
  divE  in  1  the instruction in E is a DIV or DIVU.
  div_ready  in  1  one-cycle pulse from the divider; the result is valid.
  exceptM  in  1  the instruction in M raised an exception.
  div_start  out  1  level request to the divider.
  stallF, stallD, stallE, stallM, stallW  out  1  stage stall signals.
  flushD, flushE, flushM, flushW  out  1  stage flush signals.
  forwardaD, forwardbD  out  1  forward the M-stage result to the D-stage comparator.
  forwardaE, forwardbE  out  2  select for the E-stage ALU operands.

Function
REQ-003 forwardaE SHALL be 2'b10 when rsE!=0, regwriteM=1 and rsE==writeregM.
  - Otherwise it SHALL be 2'b01 when rsE!=0, regwriteW=1 and rsE==writeregW.
  - Otherwise it SHALL be 2'b00.
  - M priority over W is mandatory.
REQ-004 forwardbE SHALL follow the rule of REQ-003, using rtE in place of rsE.
REQ-005 forwardaD SHALL be 1 when rsD!=0, regwriteM=1 and rsD==writeregM; forwardbD SHALL be the same, using rtD.
REQ-006 lwstall SHALL equal memtoregE & (rtE==rsD | rtE==rtD).
REQ-007 branchstall SHALL equal (branchD|jrD) & (a | b), where:
  - a = regwriteE & (writeregE==rsD | writeregE==rtD);
  - b = memtoregM & (writeregM==rsD | writeregM==rtD).
REQ-008 The divider FSM SHALL have exactly two states, IDLE and BUSY, and SHALL reset to IDLE.
REQ-009 From IDLE, the FSM SHALL move to BUSY when divE=1 and exceptM=0; otherwise it SHALL stay in IDLE.
REQ-010 From BUSY, the FSM SHALL move to IDLE when div_ready=1 or exceptM=1; otherwise it SHALL stay in BUSY.
REQ-011 div_start SHALL be 1 only when (IDLE & divE & ~exceptM), or when (BUSY & ~div_ready & ~exceptM).
REQ-012 divstall SHALL equal div_start.
  - In the div_ready cycle, the stall SHALL already be released so the DIV leaves E at the next edge.
  - A DIV entering E on the cycle after completion SHALL start a new operation.
REQ-013 When exceptM=0, the stall and flush outputs SHALL be:
  - stallF = stallD = lwstall | branchstall | divstall;
  - stallE = divstall;
  - flushE = (lwstall | branchstall) & ~divstall;
  - flushM = divstall (a bubble while E is held);
  - stallM = stallW = flushD = flushW = 0.
REQ-014 When exceptM=1, flushD, flushE, flushM and flushW SHALL all be 1 and all five stall outputs SHALL be 0, regardless of any other input.
REQ-015 An exception during BUSY SHALL abort the divide:
  - div_start SHALL be 0 in that cycle;
  - the state SHALL be IDLE on the next cycle;
  - a div_ready arriving later SHALL be ignored.
REQ-016 Forwarding outputs SHALL be purely combinational in the current cycle and SHALL be unaffected by stalls, flushes or the FSM state.
REQ-017 Register 0 SHALL never be a forwarding source; equality checks in REQ-006 and REQ-007 MAY match register 0, since a stall is conservative.

Reset
REQ-018 When rst=1 at a clock edge, the FSM SHALL enter IDLE, and rst SHALL override every other input at that edge.
REQ-019 In the cycle after reset, with all inputs 0, every output SHALL be 0.
REQ-020 A reset asserted while in BUSY SHALL return the FSM to IDLE on the next edge, with no residual div_start.

Verification
REQ-021 Set rsE=3, writeregM=3, regwriteM=1, writeregW=3, regwriteW=1 -> forwardaE=2'b10; then set regwriteM=0 -> forwardaE=2'b01; then set rsE=0 -> forwardaE=2'b00.
REQ-022 Set memtoregE=1, rtE=5, rsD=5 -> stallF=stallD=flushE=1 and stallE=0; the next cycle, with memtoregE=0, all outputs SHALL be 0.
REQ-023 Set branchD=1, rsD=7, regwriteE=1, writeregE=7 -> stallD=1 and flushE=1; then set memtoregM=1, writeregM=7, regwriteE=0 -> stallD=1.
REQ-024 Hold divE=1 and pulse div_ready on the 4th cycle -> div_start and stallE are 1 for cycles 1-3 and 0 in cycle 4, flushM=1 for cycles 1-3, and state is IDLE after cycle 4.
REQ-025 Hold divE=1, enter BUSY, then assert exceptM=1 -> flushD/E/M/W=1 and all stalls=0 in that cycle; state is IDLE next cycle; a later div_ready causes no change.
REQ-026 Assert rst during BUSY -> state is IDLE next cycle; with divE=0, div_start=0 and all stalls=0.
